// File: rtl/data_merger.sv
`timescale 1ns/1ps
// Packs a byte stream into OUT_W-bit words, first byte in the low lane; closes on full word, flush or idle timeout.
// Latency: a full word is presented on validOut the cycle after its last byte is accepted.
// Backpressure: one accumulator plus one output register; inReady drops only when a closing word has no free output slot.
module data_merger #(
    parameter int IN_W    = 8,
    parameter int BYTES   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  validIn,
    input  logic [IN_W-1:0]       inData8,
    output logic                  inReady,
    input  logic                  flush,
    output logic                  validOut,
    output logic [IN_W*BYTES-1:0] outData,
    output logic [3:0]            outCount,
    input  logic                  outReady
);
    localparam int OUT_W = IN_W * BYTES;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int IDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_ACC,
        ST_PEND
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IDW-1:0]   idle_q, idle_d;
    logic             vld_q, vld_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [3:0]       count_q, count_d;

    logic             slot_free;
    logic             ready;
    logic             accept;
    logic             timeout_hit;
    logic             close;
    logic [CW-1:0]    cnt_new;
    logic [OUT_W-1:0] acc_new;
    logic [IDW-1:0]   idle_inc;

    // Output register can take a word if empty or draining this cycle.
    assign slot_free = !vld_q || outReady;

    // Only the last byte of a word needs a free output slot; a held partial word blocks input entirely.
    always_comb begin
        ready = 1'b0;
        if (state_q == ST_ACC) begin
            ready = (cnt_q != CW'(BYTES - 1)) || slot_free;
        end
    end

    // Gated by reset so every output reads zero while reset is asserted.
    assign inReady = reset && ready;
    assign accept  = validIn && inReady;

    // Accumulator contents and byte count including a byte accepted this cycle.
    always_comb begin
        acc_new = acc_q;
        for (int b = 0; b < BYTES; b++) begin
            if (accept && (cnt_q == CW'(b))) begin
                acc_new[b*IN_W +: IN_W] = inData8;
            end
        end
        cnt_new = cnt_q + CW'(accept);
    end

    // Idle counter saturates at TIMEOUT; a partial word closes in the idle cycle where it reaches TIMEOUT.
    always_comb begin
        idle_inc    = (idle_q == IDW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && !accept && (cnt_q != '0) &&
                      (idle_inc == IDW'(TIMEOUT));
        close       = (cnt_new == CW'(BYTES)) || (flush && (cnt_new != '0)) || timeout_hit;
    end

    // Next-state: accumulate, close into the output register, or park a partial word in PEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idle_d  = idle_q;
        vld_d   = vld_q && !outReady;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            ST_ACC: begin
                cnt_d = cnt_new;
                acc_d = acc_new;
                if (close) begin
                    idle_d = '0;
                    if (slot_free) begin
                        vld_d   = 1'b1;
                        data_d  = acc_new;
                        count_d = 4'(cnt_new);
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = ST_PEND;
                    end
                end else if (accept || (TIMEOUT == 0) || (cnt_q == '0)) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end
            ST_PEND: begin
                idle_d = '0;
                if (slot_free) begin
                    vld_d   = 1'b1;
                    data_d  = acc_q;
                    count_d = 4'(cnt_q);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            idle_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idle_q  <= idle_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign validOut = vld_q;
    assign outData  = data_q;
    assign outCount = count_q;

endmodule
